led_fade_pwm: RTL
=================

Name: led_fade_pwm

Overview:
- Downstream stage of the AXI4 activity LED detector. It consumes the detector's level output (high = "show activity") and drives the physical LED pin.
- Replaces hard on/off switching with a PWM brightness that ramps up while the request is high and decays when it drops.
- Sits between the activity detector and the board LED pin in the Ultra96v2 design; one instance per LED.

Parameters:
- PWM_BITS, 8, width of duty and PWM counter; PWM period = 2^PWM_BITS cycles.
- STEP_CYCLES, 100_000, clock cycles per one-LSB duty change; legal range >= 1.
- DUTY_MAX, 2**PWM_BITS-1, duty ceiling reached in S_ON; legal range 1..2^PWM_BITS-1.

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset, asynchronous assert, active-low.
- led_req  input  1  activity level from the detector; sampled every clk.
- LED  output  1  registered PWM drive to the pin.
- duty  output  PWM_BITS  current linear brightness.
- busy  output  1  high in S_RISE or S_FALL.

Interface (already decided): one clock, clk. Reset reset_n is asynchronous and active-low. All flops clear immediately on reset_n low and leave reset on the first clk edge after reset_n goes high.

Behaviour:
- Reset values: LED=0, duty=0, busy=0, state=S_OFF, PWM counter=0, step timer=0.
- PWM counter is free-running 0..2^PWM_BITS-1 and wraps to 0.
- LED register next value:
  - (pwm_cntr < duty_eff), or
  - 1 when duty_eff == 2^PWM_BITS-1 (full-on, no 1/256 gap).
  - Latency from duty change to LED is 1 cycle.
- duty_eff = duty (or gamma-mapped duty, see Optional Feature).
- Step timer: counts 0..STEP_CYCLES-1 in S_RISE/S_FALL. The cycle at STEP_CYCLES-1 is the step tick; the timer then wraps to 0. It is held at 0 in S_OFF and S_ON.
- State machine:
  - S_OFF: duty=0. led_req=1 goes to S_RISE; the timer starts from 0.
  - S_RISE: on each tick, duty+1. On a tick with duty==DUTY_MAX-1, duty becomes DUTY_MAX and the state goes to S_ON. led_req=0 goes to S_FALL.
  - S_ON: duty=DUTY_MAX. led_req=0 goes to S_FALL; the timer starts from 0.
  - S_FALL: on each tick, duty-1. On a tick with duty==1, duty becomes 0 and the state goes to S_OFF. led_req=1 goes to S_RISE.
  - Illegal encoding goes to S_OFF with duty=0.
- Direction reversal (S_RISE<->S_FALL):
  - duty is kept, with no jump.
  - The step timer is NOT restarted, so the next tick arrives on the existing schedule.
- Simultaneous tick and led_req change in S_RISE/S_FALL:
  - The tick is applied in the old direction.
  - The state change takes effect in the same edge.
  - duty never leaves 0..DUTY_MAX; saturation is enforced by the compare, not by wrap.
- STEP_CYCLES==1: a tick occurs every cycle in S_RISE/S_FALL.
- Reset mid-ramp: all values are cleared immediately. After release, LED stays 0 until led_req is seen high.
- busy is combinational from state.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined: duty_eff = floor(duty^2 / 2^PWM_BITS), with duty_eff forced to 2^PWM_BITS-1 when duty==2^PWM_BITS-1. This gives a perceptually linear fade. The squaring is combinational, and its output is registered into LED with the same 1-cycle latency.
- Undefined: duty_eff = duty. No multiplier is inferred.
- The duty output port is always linear in both builds.

Decomposition:
- Package led_fade_pkg:
  - state enum {S_OFF, S_RISE, S_ON, S_FALL}.
  - function gamma_sq(duty, bits).
  - localparam for timer width = $clog2(STEP_CYCLES)+1.
- One sub-module, led_pwm_gen:
  - Contains the free-running PWM counter, compare, full-on override and LED register.
  - Parameter PWM_BITS; inputs clk, reset_n, duty_eff; output LED.
- The top module holds the FSM, step timer and duty register.

Test Plan (PWM_BITS=4, STEP_CYCLES=3, DUTY_MAX=15 unless noted):
- Reset held 10 cycles with led_req=1 -> LED=0, duty=0, busy=0 throughout. After release, busy=1 on the next edge.
- led_req=1 held -> duty increments every 3 cycles, reaches 15 after 45 cycles in S_RISE. busy then drops, and LED is constant 1 from 1 cycle after duty=15.
- From S_ON, led_req=0 -> duty decrements every 3 cycles to 0 after 45 cycles, then state S_OFF, LED constant 0.
- led_req=1 until duty=6, then 0 -> duty goes 6,5,...,0. The first decrement lands 3 cycles after the previous tick (timer not restarted), with no glitch to 7 or to 0.
- duty=8 steady (DUTY_MAX=8, non-gamma build) -> LED high exactly 8 of every 16 cycles, and the pattern repeats on counter wrap.
- With LED_FADE_GAMMA_EN, duty=8 -> duty_eff=4, LED high 4 of 16 cycles. duty=15 -> LED constant 1.

Source files
------------

// File: rtl/led_fade_pkg.sv
// led_fade_pkg: shared FSM state type and helpers for the LED fade PWM driver
package led_fade_pkg;
  typedef enum logic [1:0] {S_OFF, S_RISE, S_ON, S_FALL} state_e;
  function automatic int timer_width(input int steps);
    return $clog2(steps) + 1;
  endfunction
  function automatic logic [31:0] gamma_sq(input logic [31:0] duty, input int bits);
    logic [31:0] full;
    logic [63:0] sq;
    full = (32'd1 << bits) - 32'd1;
    sq = 64'(duty) * 64'(duty);
    return duty == full ? full : 32'(sq >> bits);
  endfunction
endpackage

// File: rtl/led_pwm_gen.sv
// led_pwm_gen: free-running PWM counter, duty compare and registered LED drive (clk, reset_n, duty_eff -> LED)
module led_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PWM_BITS-1:0] duty_eff,
  output logic                LED
);
  logic [PWM_BITS-1:0] cntr_q, cntr_d;
  logic led_q, led_d;
  always_comb begin
    cntr_d = cntr_q + 1'b1;
    led_d = &duty_eff || cntr_q < duty_eff;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cntr_q <= '0;
      led_q <= 1'b0;
    end else begin
      cntr_q <= cntr_d;
      led_q <= led_d;
    end
  end
  assign LED = led_q;
endmodule

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: ramps PWM brightness up while led_req is high and down when low (clk, reset_n, led_req -> LED, duty, busy; LED_FADE_GAMMA_EN selects squared PWM duty)
module led_fade_pwm
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 100_000,
  parameter int DUTY_MAX    = 2**PWM_BITS-1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                led_req,
  output logic                LED,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);
  localparam int TMR_W = timer_width(STEP_CYCLES);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(DUTY_MAX);
  localparam logic [PWM_BITS-1:0] MAX_M1 = PWM_BITS'(DUTY_MAX - 1);
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);
  state_e state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, duty_eff;
  logic ramp, tick, top, bottom;
  assign ramp = state_q == S_RISE || state_q == S_FALL;
  assign tick = ramp && tmr_q == LAST;
  // >= / <= also catch a reversal that happens while duty already sits at an end
  assign top = duty_q >= MAX_M1;
  assign bottom = duty_q <= ONE;
  always_comb begin
    state_d = state_q;
    duty_d = duty_q;
    // timer keeps running across a direction reversal
    tmr_d = ramp ? (tick ? '0 : tmr_q + 1'b1) : '0;
    case (state_q)
      S_OFF: begin
        duty_d = '0;
        state_d = led_req ? S_RISE : S_OFF;
      end
      S_RISE: begin
        duty_d = tick ? (top ? MAX : duty_q + 1'b1) : duty_q;
        state_d = !led_req ? S_FALL : (tick && top) ? S_ON : S_RISE;
      end
      S_ON: begin
        duty_d = MAX;
        state_d = led_req ? S_ON : S_FALL;
      end
      S_FALL: begin
        duty_d = tick ? (bottom ? '0 : duty_q - 1'b1) : duty_q;
        state_d = led_req ? S_RISE : (tick && bottom) ? S_OFF : S_FALL;
      end
      default: begin
        duty_d = '0;
        state_d = S_OFF;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_OFF;
      tmr_q <= '0;
      duty_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      duty_q <= duty_d;
    end
  end
`ifdef LED_FADE_GAMMA_EN
  assign duty_eff = PWM_BITS'(gamma_sq(32'(duty_q), PWM_BITS));
`else
  assign duty_eff = duty_q;
`endif
  led_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk(clk),
    .reset_n(reset_n),
    .duty_eff(duty_eff),
    .LED(LED)
  );
  assign duty = duty_q;
  assign busy = ramp;
endmodule
